imem_dmem_arbiter: RTL and testbench
====================================

// Module: imem_dmem_arbiter
// PURPOSE
//   Shares one backing-memory port between the instruction cache (read-only
//   I-side) and the data cache (read/write D-side). It sits between both
//   cache o_mem_* interfaces and the single external memory port.
//   Grants are locked per transaction burst, arbitrated round-robin, and
//   read responses are routed back to the owner of the outstanding reads.
// PARAMETERS
//   MAX_OUTSTANDING  4   max accepted-but-unreturned reads (1..15)
//   CNT_W            4   width of outstanding counter; must hold MAX_OUTSTANDING
// PORTS
//   i_clk           in   1   clock
//   i_rst           in   1   reset, synchronous, active-high
//   i_ic_addr       in   32  I-side request address
//   i_ic_ren        in   1   I-side read request; held steady until o_ic_ready
//   o_ic_ready      out  1   I-side request accepted this cycle
//   o_ic_valid      out  1   I-side read data valid
//   o_ic_rdata      out  32  I-side read data
//   i_dc_addr       in   32  D-side request address
//   i_dc_ren        in   1   D-side read request
//   i_dc_wen        in   1   D-side write request (ren/wen mutually exclusive)
//   i_dc_wdata      in   32  D-side write data
//   o_dc_ready      out  1   D-side request accepted this cycle
//   o_dc_valid      out  1   D-side read data valid
//   o_dc_rdata      out  32  D-side read data
//   o_mem_addr      out  32  memory address (granted client)
//   o_mem_ren       out  1   memory read strobe
//   o_mem_wen       out  1   memory write strobe
//   o_mem_wdata     out  32  memory write data
//   i_mem_ready     in   1   memory accepts strobe this cycle
//   i_mem_valid     in   1   memory read data valid (in order)
//   i_mem_rdata     in   32  memory read data
//   o_grant         out  2   2'b00 idle, 2'b01 I-side, 2'b10 D-side
//   o_proto_err     out  1   sticky: i_mem_valid seen with zero outstanding
// BEHAVIOUR
// - Reset: state IDLE, outstanding=0, rr_last=D (so I wins first tie), all
//   outputs 0, o_grant=00, o_proto_err=0. Any in-flight transfer is abandoned;
//   memory is reset by the same i_rst.
// - FSM IDLE/GNT_I/GNT_D, registered; 1-cycle arbitration latency:
//   IDLE: only I req -> GNT_I; only D req (ren|wen) -> GNT_D; both -> the
//   side != rr_last. No req -> stay. No strobes forwarded while IDLE.
// - In GNT_x: mem addr/ren/wen/wdata = granted client's signals (I: wen=0,
//   wdata=0); non-granted side's ready=0, its fields ignored. Ungranted
//   o_mem_* driven 0.
// - Accept: o_x_ready = granted & req & i_mem_ready & ~full, where
//   full = (outstanding==MAX_OUTSTANDING) & ren. When full, o_mem_ren forced 0.
//   Writes complete on acceptance; they do not count as outstanding.
// - Counter: +1 on accepted read, -1 on i_mem_valid, both same cycle ->
//   unchanged. Never wraps; valid at 0 is dropped and sets o_proto_err.
// - Response routing: i_mem_valid/rdata go to owner (current grant) combin-
//   ationally, zero latency; other side's valid=0, rdata=0.
// - Release: when granted req is low AND outstanding==0 (after any decrement
//   this cycle), leave GNT_x: other side requesting -> GNT_other directly,
//   else IDLE. rr_last <= released side. Grant never changes with reads
//   outstanding, guaranteeing response ownership.
// - Req deasserted then reasserted while outstanding>0: grant held, request
//   served in same grant (burst continuation).
// TESTING
// - Reset, both idle -> o_grant=00, all strobes 0; I req @0x0 -> cycle+1
//   o_grant=01, o_mem_ren=1 addr 0x0.
// - Both request same cycle from reset -> I granted first; after I drops and
//   returns data, D granted on the release cycle (no IDLE gap).
// - I issues 4 reads with i_mem_ready=1, valid withheld -> 5th read blocked
//   (o_ic_ready=0, o_mem_ren=0) until one valid returns.
// - D read in flight, D req drops, I requests -> grant stays 10 until
//   D's o_dc_valid with rdata 0xDEADBEEF, then o_grant=01.
// - D write 0x12345678 @0x100 with i_mem_ready low 3 cycles -> wen/addr/wdata
//   held, o_dc_ready pulses once, outstanding stays 0.
// - i_mem_valid with outstanding=0 -> no client valid, o_proto_err=1 until reset.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one backing-memory port between the instruction cache (read-only)
//   and the data cache (read/write). A grant is locked for a whole burst and
//   is released only once the granted side has dropped its request and every
//   read it issued has returned. Ties are broken round-robin, and read
//   responses are routed back to the current grant holder with no latency.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ic_*/o_ic_*       I-side request (addr, ren) / accept and response
//   i_dc_*/o_dc_*       D-side request (addr, ren, wen, wdata) / accept and response
//   o_mem_*/i_mem_*     single external memory port
//   o_grant             00 idle, 01 I-side, 10 D-side
//   o_proto_err         sticky: memory returned data with nothing outstanding

module imem_dmem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [31:0] i_ic_addr,
    input  logic        i_ic_ren,
    output logic        o_ic_ready,
    output logic        o_ic_valid,
    output logic [31:0] o_ic_rdata,

    input  logic [31:0] i_dc_addr,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic        o_dc_valid,
    output logic [31:0] o_dc_rdata,

    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,

    output logic [1:0]  o_grant,
    output logic        o_proto_err
);

    // Encodings match o_grant so the state register drives it directly.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGntI = 2'b01,
        StGntD = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_OUTSTANDING);

    state_t           state;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic             rr_last_d;     // 1: D-side was released last, 0: I-side
    logic             proto_err;

    logic ic_req;
    logic dc_req;
    logic gnt_i;
    logic gnt_d;
    logic grant_ren;
    logic full;
    logic read_accept;
    logic resp_ok;

    assign ic_req = i_ic_ren;
    assign dc_req = i_dc_ren | i_dc_wen;
    assign gnt_i  = (state == StGntI);
    assign gnt_d  = (state == StGntD);

    // Only a pending read is throttled by the outstanding limit; writes pass.
    assign grant_ren = (gnt_i & i_ic_ren) | (gnt_d & i_dc_ren);
    assign full      = (outstanding == CntMax) & grant_ren;

    assign o_ic_ready = gnt_i & ic_req & i_mem_ready & ~full;
    assign o_dc_ready = gnt_d & dc_req & i_mem_ready & ~full;

    assign read_accept = o_ic_ready | (o_dc_ready & i_dc_ren);
    // A response with nothing outstanding is dropped and flagged.
    assign resp_ok     = i_mem_valid & (outstanding != '0);

    always_comb begin
        outstanding_nxt = outstanding;
        case ({read_accept, resp_ok})
            2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
            2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // Memory-side request mux; ungranted means all zero.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        if (gnt_i) begin
            o_mem_addr = i_ic_addr;
            o_mem_ren  = i_ic_ren & ~full;
        end else if (gnt_d) begin
            o_mem_addr  = i_dc_addr;
            o_mem_ren   = i_dc_ren & ~full;
            o_mem_wen   = i_dc_wen;
            o_mem_wdata = i_dc_wdata;
        end
    end

    // Responses belong to the grant holder: the grant cannot move while
    // reads are outstanding.
    always_comb begin
        o_ic_valid = 1'b0;
        o_ic_rdata = '0;
        o_dc_valid = 1'b0;
        o_dc_rdata = '0;
        if (resp_ok && gnt_i) begin
            o_ic_valid = 1'b1;
            o_ic_rdata = i_mem_rdata;
        end else if (resp_ok && gnt_d) begin
            o_dc_valid = 1'b1;
            o_dc_rdata = i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= StIdle;
            outstanding <= '0;
            rr_last_d   <= 1'b1;
            proto_err   <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (i_mem_valid && outstanding == '0) begin
                proto_err <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (ic_req && dc_req) begin
                        state <= rr_last_d ? StGntI : StGntD;
                    end else if (ic_req) begin
                        state <= StGntI;
                    end else if (dc_req) begin
                        state <= StGntD;
                    end
                end
                StGntI: begin
                    if (!ic_req && outstanding_nxt == '0) begin
                        rr_last_d <= 1'b0;
                        state     <= dc_req ? StGntD : StIdle;
                    end
                end
                StGntD: begin
                    if (!dc_req && outstanding_nxt == '0) begin
                        rr_last_d <= 1'b1;
                        state     <= ic_req ? StGntI : StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign o_grant     = state;
    assign o_proto_err = proto_err;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
//   Directed test of imem_dmem_arbiter. Inputs change 1 ns after a rising
//   edge; outputs are checked 1 ns later, well before the next rising edge.

module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_addr;
    logic        ic_ren;
    logic        ic_ready;
    logic        ic_valid;
    logic [31:0] ic_rdata;
    logic [31:0] dc_addr;
    logic        dc_ren;
    logic        dc_wen;
    logic [31:0] dc_wdata;
    logic        dc_ready;
    logic        dc_valid;
    logic [31:0] dc_rdata;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .MAX_OUTSTANDING(4),
        .CNT_W          (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ic_addr  (ic_addr),
        .i_ic_ren   (ic_ren),
        .o_ic_ready (ic_ready),
        .o_ic_valid (ic_valid),
        .o_ic_rdata (ic_rdata),
        .i_dc_addr  (dc_addr),
        .i_dc_ren   (dc_ren),
        .i_dc_wen   (dc_wen),
        .i_dc_wdata (dc_wdata),
        .o_dc_ready (dc_ready),
        .o_dc_valid (dc_valid),
        .o_dc_rdata (dc_rdata),
        .o_mem_addr (mem_addr),
        .o_mem_ren  (mem_ren),
        .o_mem_wen  (mem_wen),
        .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready),
        .i_mem_valid(mem_valid),
        .i_mem_rdata(mem_rdata),
        .o_grant    (grant),
        .o_proto_err(proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ic_addr   = '0;
        ic_ren    = 1'b0;
        dc_addr   = '0;
        dc_ren    = 1'b0;
        dc_wen    = 1'b0;
        dc_wdata  = '0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state
        settle();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_mem_ren", 32'(mem_ren), 32'h0);
        check("rst_mem_wen", 32'(mem_wen), 32'h0);
        check("rst_proto", 32'(proto_err), 32'h0);

        // Single I read from idle: one cycle of arbitration latency
        step();
        ic_ren = 1'b1; ic_addr = 32'h0; mem_ready = 1'b1;
        settle();
        check("idle_no_strobe", 32'(mem_ren), 32'h0);
        check("idle_no_ready", 32'(ic_ready), 32'h0);
        step();
        settle();
        check("i_grant", 32'(grant), 32'h1);
        check("i_mem_ren", 32'(mem_ren), 32'h1);
        check("i_mem_addr", mem_addr, 32'h0);
        check("i_ready", 32'(ic_ready), 32'h1);
        step();
        ic_ren = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'hA5A5_0001;
        settle();
        check("i_valid", 32'(ic_valid), 32'h1);
        check("i_rdata", ic_rdata, 32'hA5A5_0001);
        check("i_dc_valid_0", 32'(dc_valid), 32'h0);
        step();
        mem_valid = 1'b0;
        settle();
        check("i_release_idle", 32'(grant), 32'h0);

        // Simultaneous requests from reset: I first, then D with no idle gap
        do_reset();
        ic_ren = 1'b1; ic_addr = 32'h40;
        dc_ren = 1'b1; dc_addr = 32'h80;
        mem_ready = 1'b1;
        step();
        settle();
        check("tie_grant_i", 32'(grant), 32'h1);
        check("tie_addr_i", mem_addr, 32'h40);
        check("tie_dc_ready_0", 32'(dc_ready), 32'h0);
        step();
        ic_ren = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
        settle();
        check("tie_i_valid", 32'(ic_valid), 32'h1);
        step();
        mem_valid = 1'b0;
        settle();
        check("tie_grant_d", 32'(grant), 32'h2);
        check("tie_addr_d", mem_addr, 32'h80);
        check("tie_d_ren", 32'(mem_ren), 32'h1);
        check("tie_d_ready", 32'(dc_ready), 32'h1);

        // D read outstanding, D drops, I waits until D's data returns
        step();
        dc_ren = 1'b0; ic_ren = 1'b1; ic_addr = 32'h44;
        settle();
        check("hold_grant_d", 32'(grant), 32'h2);
        check("hold_ic_ready_0", 32'(ic_ready), 32'h0);
        step();
        settle();
        check("hold_grant_d2", 32'(grant), 32'h2);
        mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("hold_dc_valid", 32'(dc_valid), 32'h1);
        check("hold_dc_rdata", dc_rdata, 32'hDEAD_BEEF);
        check("hold_ic_valid_0", 32'(ic_valid), 32'h0);
        check("hold_ic_rdata_0", ic_rdata, 32'h0);
        step();
        mem_valid = 1'b0;
        settle();
        check("handover_grant_i", 32'(grant), 32'h1);
        check("handover_ic_ready", 32'(ic_ready), 32'h1);

        // Four reads fill the window; the fifth waits for a response
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(ic_ready), 32'h1);
            step();
        end
        check("full_ic_ready_0", 32'(ic_ready), 32'h0);
        check("full_mem_ren_0", 32'(mem_ren), 32'h0);
        step();
        check("full_still_blocked", 32'(ic_ready), 32'h0);
        mem_valid = 1'b1; mem_rdata = 32'h0000_0004;
        settle();
        check("full_resp_valid", 32'(ic_valid), 32'h1);
        check("full_resp_blocked", 32'(ic_ready), 32'h0);
        step();
        mem_valid = 1'b0;
        settle();
        check("unblock_ready", 32'(ic_ready), 32'h1);
        check("unblock_mem_ren", 32'(mem_ren), 32'h1);
        step();
        ic_ren = 1'b0;
        mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_valid", 32'(ic_valid), 32'h1);
            check("drain_grant", 32'(grant), 32'h1);
            step();
        end
        mem_valid = 1'b0;
        settle();
        check("drain_release", 32'(grant), 32'h0);

        // D write with memory stalled for three cycles
        dc_wen = 1'b1; dc_addr = 32'h100; dc_wdata = 32'h1234_5678;
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("wr_grant", 32'(grant), 32'h2);
            check("wr_wen", 32'(mem_wen), 32'h1);
            check("wr_addr", mem_addr, 32'h100);
            check("wr_wdata", mem_wdata, 32'h1234_5678);
            check("wr_stall_ready", 32'(dc_ready), 32'h0);
            step();
        end
        mem_ready = 1'b1;
        settle();
        check("wr_accept", 32'(dc_ready), 32'h1);
        check("wr_no_ren", 32'(mem_ren), 32'h0);
        step();
        dc_wen = 1'b0;
        settle();
        check("wr_ready_once", 32'(dc_ready), 32'h0);
        check("wr_wen_drop", 32'(mem_wen), 32'h0);
        // Release on the very next edge proves the write never counted
        step();
        check("wr_release", 32'(grant), 32'h0);

        // Stray response with nothing outstanding
        mem_valid = 1'b1; mem_rdata = 32'h5555_5555;
        settle();
        check("stray_ic_valid", 32'(ic_valid), 32'h0);
        check("stray_dc_valid", 32'(dc_valid), 32'h0);
        step();
        mem_valid = 1'b0;
        settle();
        check("proto_set", 32'(proto_err), 32'h1);
        step();
        step();
        check("proto_sticky", 32'(proto_err), 32'h1);
        do_reset();
        settle();
        check("proto_cleared", 32'(proto_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
